cache_fill_fsm: RTL and testbench

- Miss handler that refills one 8-word cache block from the multi-cycle main memory into the cache data array, and then updates the tag array.
- On a miss it latches the miss address and issues 8 sequential word reads. Each returning word is steered into the data array with one-hot block/word enables and a write strobe.
- Sits between the cache hit/miss logic and memory, and drives the data-array write port.

---
 rtl/cache_fill_fsm_pkg.sv | 19 +
 rtl/cache_fill_fsm_onehot_decoder.sv | 17 +
 rtl/cache_fill_fsm.sv | 162 ++++++++++++++++
 tb/tb_cache_fill_fsm.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache block-fill miss handler.
// The state encoding is fixed so that the dbg_state output can be checked directly.
package cache_fill_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        DONE = 2'b10
    } fill_state_t;

    // Byte-address field layout: | tag | index | offset |
    localparam int OFFSET_W = 4;
    localparam int INDEX_W  = 7;
    localparam int TAG_W    = 5;

    localparam int BLOCKS = 128;
    localparam int WORDS  = 8;

endpackage

// File: rtl/cache_fill_fsm_onehot_decoder.sv
// Binary to one-hot decoder with an enable; the output is all-zero when disabled.
module onehot_decoder #(
    parameter int N = 3
) (
    input  logic                i_en,
    input  logic [N-1:0]        i_sel,
    output logic [(1<<N)-1:0]   o_onehot
);

    localparam int M = 1 << N;

    logic [M-1:0] w_one;

    assign w_one    = M'(1);
    assign o_onehot = i_en ? (w_one << i_sel) : '0;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss handler: refills one WORDS-word block from main memory into the cache
// data array, then pulses the tag-array update for one cycle.
// Optional statistics counters are compiled in with `define CACHE_FILL_STATS_EN.
//
// Memory interface: mem_read_en is a one-cycle read request with
// memory_address; memory never back-pressures, so every cycle with
// mem_read_en=1 is one accepted read. memory_data_valid marks one returned
// word per cycle, in issue order, with no ready signal on our side: a word
// presented while a fill is in progress is always consumed that cycle.
import cache_fill_fsm_pkg::*;

module cache_fill_fsm #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_detected,
    input  logic [ADDR_W-1:0]   miss_address,
    input  logic                memory_data_valid,
    input  logic [DATA_W-1:0]   memory_data,
    output logic                fsm_busy,
    output logic                mem_read_en,
    output logic [ADDR_W-1:0]   memory_address,
    output logic                write_data_array,
    output logic [BLOCKS-1:0]   block_enable,
    output logic [WORDS-1:0]    word_enable,
    output logic [DATA_W-1:0]   data_out,
    output logic                write_tag_array,
    output logic [1:0]          dbg_state
`ifdef CACHE_FILL_STATS_EN
    ,
    output logic [15:0]         fill_count,
    output logic [15:0]         busy_cycles
`endif
);

    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W:0]   LAST_ISSUE = (CNT_W+1)'(WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_RET   = CNT_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(2);

    fill_state_t        r_state;
    logic [CNT_W:0]     r_issue_cnt;   // reads issued, saturates at WORDS
    logic [CNT_W-1:0]   r_ret_cnt;     // words written back so far
    logic [ADDR_W-1:0]  r_base;        // block-aligned miss address
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_read_en;
    logic               r_busy;
    logic               r_tag_wr;

    logic               w_write;
    logic [INDEX_W-1:0] w_index;

    // Returning words are written in the same cycle they arrive.
    assign w_write = (r_state == FILL) && memory_data_valid;
    assign w_index = r_base[OFFSET_W+INDEX_W-1:OFFSET_W];

    // Fill controller: state, counters and registered request/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_issue_cnt   <= '0;
            r_ret_cnt     <= '0;
            r_base        <= '0;
            r_mem_addr    <= '0;
            r_mem_read_en <= 1'b0;
            r_busy        <= 1'b0;
            r_tag_wr      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_detected) begin
                        r_state       <= FILL;
                        r_base        <= {miss_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        r_mem_addr    <= {miss_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        r_mem_read_en <= 1'b1;
                        r_busy        <= 1'b1;
                        r_issue_cnt   <= '0;
                        r_ret_cnt     <= '0;
                    end
                end
                FILL: begin
                    // The request registers already hold this cycle's read;
                    // prepare the next one or stop after the last word.
                    if (r_mem_read_en) begin
                        r_issue_cnt <= r_issue_cnt + (CNT_W+1)'(1);
                        if (r_issue_cnt < LAST_ISSUE) begin
                            r_mem_addr <= r_mem_addr + WORD_STEP;
                        end else begin
                            r_mem_read_en <= 1'b0;
                            r_mem_addr    <= '0;
                        end
                    end
                    if (memory_data_valid) begin
                        r_ret_cnt <= r_ret_cnt + CNT_W'(1);
                        if (r_ret_cnt == LAST_RET) begin
                            r_state       <= DONE;
                            r_tag_wr      <= 1'b1;
                            r_mem_read_en <= 1'b0;
                            r_mem_addr    <= '0;
                        end
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_tag_wr    <= 1'b0;
                    r_busy      <= 1'b0;
                    r_issue_cnt <= '0;
                    r_ret_cnt   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    onehot_decoder #(.N(INDEX_W)) u_block_dec (
        .i_en     (w_write),
        .i_sel    (w_index),
        .o_onehot (block_enable)
    );

    onehot_decoder #(.N(CNT_W)) u_word_dec (
        .i_en     (w_write),
        .i_sel    (r_ret_cnt),
        .o_onehot (word_enable)
    );

    assign fsm_busy         = r_busy;
    assign mem_read_en      = r_mem_read_en;
    assign memory_address   = r_mem_addr;
    assign write_data_array = w_write;
    assign data_out         = w_write ? memory_data : '0;
    assign write_tag_array  = r_tag_wr;
    assign dbg_state        = r_state;

`ifdef CACHE_FILL_STATS_EN
    logic [15:0] r_fill_count;
    logic [15:0] r_busy_cycles;

    // Completed fills and stalled cycles; both wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_count  <= '0;
            r_busy_cycles <= '0;
        end else begin
            if (r_tag_wr) begin
                r_fill_count <= r_fill_count + 16'd1;
            end
            if (r_busy) begin
                r_busy_cycles <= r_busy_cycles + 16'd1;
            end
        end
    end

    assign fill_count  = r_fill_count;
    assign busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a latency/gap-configurable memory
// responder feeds the DUT, and a transaction-level model of the block fill
// predicts every output cycle by cycle.
module tb_cache_fill_fsm;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_detected;
  logic [15:0]   miss_address;
  logic          memory_data_valid;
  logic [15:0]   memory_data;
  logic          fsm_busy;
  logic          mem_read_en;
  logic [15:0]   memory_address;
  logic          write_data_array;
  logic [127:0]  block_enable;
  logic [7:0]    word_enable;
  logic [15:0]   data_out;
  logic          write_tag_array;
  logic [1:0]    dbg_state;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0]   fill_count;
  logic [15:0]   busy_cycles;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .block_enable      (block_enable),
    .word_enable       (word_enable),
    .data_out          (data_out),
    .write_tag_array   (write_tag_array),
    .dbg_state         (dbg_state)
`ifdef CACHE_FILL_STATS_EN
    ,
    .fill_count        (fill_count),
    .busy_cycles       (busy_cycles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // memory responder: outstanding reads in issue order
  int          pend_t[$];
  logic [15:0] pend_d[$];
  int          lat       = 4;
  bit          gap_mode  = 0;
  int          gap_phase = 0;
  bit          noise     = 0;

  // block-fill model
  bit          m_filling = 0;
  bit          m_tagging = 0;
  logic [15:0] m_base    = '0;
  int          m_reads   = 0;
  int          m_writes  = 0;
  int          m_fills   = 0;
  int          m_busy_cnt = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // one clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input bit miss, input logic [15:0] addr, input bit do_rst);
    logic          v;
    logic [15:0]   d;
    logic          e_busy, e_rd, e_wr, e_tag;
    logic [15:0]   e_addr, e_data;
    logic [7:0]    e_word;
    logic [127:0]  e_blk;
    logic [1:0]    e_state;
    logic [6:0]    idx;
    @(posedge clk);
    #1;
    cyc++;
    v = 1'b0;
    d = 16'($urandom);
    if (pend_t.size() > 0 && pend_t[0] + lat <= cyc) begin
      if (!gap_mode || gap_phase == 0) begin
        v = 1'b1;
        d = pend_d.pop_front();
        void'(pend_t.pop_front());
      end
      if (gap_mode) gap_phase = (gap_phase + 1) % 3;
    end else if (pend_t.size() == 0 && noise && !m_filling) begin
      v = 1'($urandom_range(0, 1));
    end
    rst               = do_rst;
    miss_detected     = miss;
    miss_address      = addr;
    memory_data_valid = v;
    memory_data       = d;
    #1;
    idx     = m_base[10:4];
    e_busy  = m_filling || m_tagging;
    e_rd    = m_filling && (m_reads < 8);
    e_addr  = e_rd ? m_base + 16'(2 * m_reads) : 16'h0;
    e_wr    = m_filling && v;
    e_word  = e_wr ? (8'(1) << m_writes) : 8'h0;
    e_blk   = e_wr ? (128'(1) << idx) : 128'h0;
    e_data  = e_wr ? d : 16'h0;
    e_tag   = m_tagging;
    e_state = m_filling ? 2'd1 : (m_tagging ? 2'd2 : 2'd0);

    check_val("fsm_busy",         128'(fsm_busy),         128'(e_busy));
    check_val("mem_read_en",      128'(mem_read_en),      128'(e_rd));
    check_val("memory_address",   128'(memory_address),   128'(e_addr));
    check_val("write_data_array", 128'(write_data_array), 128'(e_wr));
    check_val("word_enable",      128'(word_enable),      128'(e_word));
    check_val("block_enable",     block_enable,           e_blk);
    check_val("data_out",         128'(data_out),         128'(e_data));
    check_val("write_tag_array",  128'(write_tag_array),  128'(e_tag));
    check_val("state",            128'(dbg_state),        128'(e_state));
`ifdef CACHE_FILL_STATS_EN
    check_val("fill_count",       128'(fill_count),       128'(16'(m_fills)));
    check_val("busy_cycles",      128'(busy_cycles),      128'(16'(m_busy_cnt)));
`endif

    if (e_rd) begin
      pend_t.push_back(cyc);
      pend_d.push_back(16'($urandom));
    end

    if (e_busy) m_busy_cnt++;
    if (m_tagging) begin
      m_tagging = 0;
      m_fills++;
    end else if (m_filling) begin
      if (e_rd) m_reads++;
      if (e_wr) begin
        m_writes++;
        if (m_writes == 8) begin
          m_filling = 0;
          m_tagging = 1;
        end
      end
    end else if (miss) begin
      m_filling = 1;
      m_base    = {addr[15:4], 4'h0};
      m_reads   = 0;
      m_writes  = 0;
    end
    if (do_rst) begin
      m_filling  = 0;
      m_tagging  = 0;
      m_fills    = 0;
      m_busy_cnt = 0;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int k = 0;
    while ((m_filling || m_tagging) && k < budget) begin
      step(1'b0, 16'h0, 1'b0);
      k++;
    end
  endtask

  task automatic do_fill(input logic [15:0] addr, input int latency, input bit gaps);
    lat       = latency;
    gap_mode  = gaps;
    gap_phase = 0;
    step(1'b1, addr, 1'b0);
    run_until_idle(300);
  endtask

  initial begin
    int f0;
    int k;
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = '0;
    memory_data_valid = 1'b0;
    memory_data       = '0;
    repeat (3) @(posedge clk);

    // reset state, then idle with stray memory valids
    noise = 1;
    repeat (8) step(1'b0, 16'($urandom), 1'b0);

    // directed miss at 16'h1236 with 4-cycle memory latency
    do_fill(16'h1236, 4, 1'b0);
    step(1'b0, 16'h0, 1'b0);

    // returns with gaps (1,0,0,1,...)
    do_fill(16'hA5C8, 3, 1'b1);
    step(1'b0, 16'h0, 1'b0);

    // miss held through FILL and DONE, accepted on the first IDLE cycle
    lat = 2; gap_mode = 0;
    f0 = m_fills;
    step(1'b1, 16'h0F12, 1'b0);
    k = 0;
    while (m_fills == f0 && k < 300) begin
      step(1'b1, 16'h7E44, 1'b0);
      k++;
    end
    step(1'b1, 16'h7E44, 1'b0);
    run_until_idle(300);

    // reset after the third return aborts the fill; late returns are dropped
    noise = 0;
    lat = 2; gap_mode = 0;
    step(1'b1, 16'h3C70, 1'b0);
    k = 0;
    while (m_writes < 3 && k < 100) begin
      step(1'b0, 16'h0, 1'b0);
      k++;
    end
    step(1'b0, 16'h0, 1'b1);
    repeat (12) step(1'b0, 16'h0, 1'b0);
    pend_t.delete();
    pend_d.delete();

    // randomized fills
    noise = 1;
    for (int i = 0; i < 6; i++) begin
      do_fill(16'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) step(1'b0, 16'($urandom), 1'b0);
    end

    // three back-to-back fills with latency 4 (statistics accumulate here)
    for (int i = 0; i < 3; i++) begin
      do_fill(16'($urandom), 4, 1'b0);
    end
    repeat (2) step(1'b0, 16'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
